// File: rtl/wavegen_pkg.sv
// Purpose: shared word/frame geometry and control-frame FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wavegen_pkg;

  localparam int WORD_W_DEF    = 16;
  localparam int NUM_WORDS_DEF = 64;
  localparam int ADDR_W_DEF    = 6;

  // ST_CSUM is only reachable when the checksum beat is built in
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CSUM   = 2'd2
  } state_t;

endpackage

// File: rtl/frame_word_mux.sv
// Purpose: select one word of the shadowed frame by address.
// Latency: combinational.
// Backpressure: none; the caller holds the address stable while stalled.
module frame_word_mux
  import wavegen_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic [WORD_W*NUM_WORDS-1:0] i_shadow,
  input  logic [ADDR_W-1:0]           i_addr,
  output logic [WORD_W-1:0]           o_word
);

  // Explicit compare per word so addresses beyond NUM_WORDS-1 read as zero
  always_comb begin
    o_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (i_addr == ADDR_W'(k)) begin
        o_word = i_shadow[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/control_frame_serializer.sv
// Purpose: snapshot a combined control frame and stream it word by word (optional XOR checksum beat, macro CHECKSUM_EN).
// Latency: word 0 is valid the cycle after the load edge; frame_done one cycle after the final transfer.
// Backpressure: valid/ready; the current word is held while ready is low, valid never drops mid-frame.
module control_frame_serializer
  import wavegen_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W*NUM_WORDS-1:0] frame_in,
  input  logic                        frame_load,
  output logic                        busy,
  output logic [WORD_W-1:0]           word_out,
  output logic [ADDR_W-1:0]           word_addr,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        word_last,
  output logic                        word_csum,
  output logic                        frame_done,
  output logic                        load_overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [WORD_W*NUM_WORDS-1:0] r_shadow;
  logic [ADDR_W-1:0]           r_addr;
  logic                        r_frame_done;
  logic                        r_overrun;
  logic [WORD_W-1:0]           w_mux_word;
  logic                        w_xfer;
  logic                        w_at_end;
  logic                        w_final;
  logic                        w_load_acc;

  assign w_xfer   = word_valid && word_ready;
  assign w_at_end = (r_addr == LAST_ADDR);

`ifdef CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;
  logic [WORD_W-1:0] w_frame_xor;

  // The frame ends on the checksum beat
  assign w_final = w_xfer && (r_state == ST_CSUM);

  // XOR of the incoming frame, ready to be captured alongside the snapshot
  always_comb begin
    w_frame_xor = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_frame_xor = w_frame_xor ^ frame_in[k*WORD_W +: WORD_W];
    end
  end

  // Checksum captured with the snapshot so the extra beat costs no latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_load_acc) begin
      r_csum <= w_frame_xor;
    end
  end
`else
  // The frame ends on the last data word
  assign w_final = w_xfer && (r_state == ST_STREAM) && w_at_end;
`endif

  // A load is taken when idle, or when it lands on the final transfer (back-to-back frames)
  assign w_load_acc = frame_load && ((r_state == ST_IDLE) || w_final);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (frame_load) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_xfer && w_at_end) begin
`ifdef CHECKSUM_EN
          w_state_nxt = ST_CSUM;
`else
          w_state_nxt = frame_load ? ST_STREAM : ST_IDLE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        if (w_xfer) w_state_nxt = frame_load ? ST_STREAM : ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot and beat counter; the counter saturates at the last word and only a load rewinds it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_addr   <= '0;
    end else if (w_load_acc) begin
      r_shadow <= frame_in;
      r_addr   <= '0;
    end else if (w_xfer && (r_state == ST_STREAM) && !w_at_end) begin
      r_addr   <= r_addr + ADDR_W'(1);
    end
  end

  // Completion pulse and sticky record of dropped loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_final;
      if (frame_load && (r_state != ST_IDLE) && !w_final) begin
        r_overrun <= 1'b1;
      end
    end
  end

  frame_word_mux #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_word_mux (
    .i_shadow(r_shadow),
    .i_addr  (r_addr),
    .o_word  (w_mux_word)
  );

  // Beat outputs decoded from the state; everything reads zero while idle
  always_comb begin
    busy       = 1'b0;
    word_valid = 1'b0;
    word_out   = '0;
    word_addr  = '0;
    word_last  = 1'b0;
    word_csum  = 1'b0;
    case (r_state)
      ST_STREAM: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_out   = w_mux_word;
        word_addr  = r_addr;
`ifndef CHECKSUM_EN
        word_last  = w_at_end;
`endif
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_out   = r_csum;
        word_addr  = '0;
        word_last  = 1'b1;
        word_csum  = 1'b1;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign frame_done   = r_frame_done;
  assign load_overrun = r_overrun;

endmodule

// File: tb/tb_control_frame_serializer.sv
// Purpose: randomized bench for control_frame_serializer against a beat-queue reference model.
// Latency: model predicts each displayed beat one cycle ahead from accepted loads.
// Backpressure: word_ready driven fixed, alternating or random per test phase.
module tb_control_frame_serializer;

  localparam int NW = 64;
  localparam int WW = 16;

  typedef struct packed {
    logic [15:0] w;
    logic [5:0]  a;
    logic        l;
    logic        c;
  } beat_t;

  logic             clk;
  logic             rst;
  logic [WW*NW-1:0] frame_in;
  logic             frame_load;
  logic             busy;
  logic [WW-1:0]    word_out;
  logic [5:0]       word_addr;
  logic             word_valid;
  logic             word_ready;
  logic             word_last;
  logic             word_csum;
  logic             frame_done;
  logic             load_overrun;

  int    n_chk;
  int    n_fail;
  int    rdy_mode;
  int    n_vobs;
  int    n_done_obs;
  int    n_csum_obs;
  beat_t q[$];
  logic  exp_done;
  logic  exp_ovr;
  logic  exp_valid;
  logic  xfer;
  logic  fin;

  control_frame_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_load  (frame_load),
    .busy        (busy),
    .word_out    (word_out),
    .word_addr   (word_addr),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_last   (word_last),
    .word_csum   (word_csum),
    .frame_done  (frame_done),
    .load_overrun(load_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: a frame is the list of beats the consumer must see, in order
  function automatic void push_frame();
    logic [15:0] x;
    x = '0;
    for (int k = 0; k < NW; k++) begin
      beat_t b;
      b.w = frame_in[k*WW +: WW];
      b.a = 6'(k);
`ifdef CHECKSUM_EN
      b.l = 1'b0;
`else
      b.l = (k == NW - 1);
`endif
      b.c = 1'b0;
      x = x ^ b.w;
      q.push_back(b);
    end
`ifdef CHECKSUM_EN
    q.push_back('{w: x, a: 6'd0, l: 1'b1, c: 1'b1});
`endif
  endfunction

  // Monitor and model step, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_done = 1'b0;
      exp_ovr  = 1'b0;
    end else begin
      exp_valid = (q.size() != 0);
      check_eq("valid", word_valid, exp_valid);
      check_eq("busy", busy, exp_valid);
      check_eq("frame_done", frame_done, exp_done);
      check_eq("overrun", load_overrun, exp_ovr);
      if (exp_valid) begin
        check_eq("word_out", word_out, q[0].w);
        check_eq("word_addr", word_addr, q[0].a);
        check_eq("word_last", word_last, q[0].l);
        check_eq("word_csum", word_csum, q[0].c);
      end
      if (word_valid) n_vobs++;
      if (frame_done) n_done_obs++;
      if (word_valid && word_ready && word_csum) n_csum_obs++;
      xfer = exp_valid && word_ready;
      fin  = xfer && (q.size() == 1);
      if (xfer) q.delete(0);
      if (frame_load) begin
        if (!exp_valid || fin) push_frame();
        else exp_ovr = 1'b1;
      end
      exp_done = fin;
    end
  end

  // Consumer ready pattern
  initial begin
    word_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       word_ready = 1'b1;
        1:       word_ready = ~word_ready;
        default: word_ready = ($urandom % 3) != 0;
      endcase
    end
  end

  task automatic pulse_load();
    frame_load = 1'b1;
    @(posedge clk);
    #2;
    frame_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input string tag, input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (q.size() > 1 && q[0].a == 6'(target)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_final(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NW; k++) frame_in[k*WW +: WW] = 16'($urandom);
  endtask

  initial begin
    int exp_vcyc;
    bit ok;
    n_chk      = 0;
    n_fail     = 0;
    rdy_mode   = 0;
    rst        = 1'b1;
    frame_load = 1'b0;
    frame_in   = '0;
    n_vobs     = 0;
    n_done_obs = 0;
    n_csum_obs = 0;
    exp_done   = 1'b0;
    exp_ovr    = 1'b0;
`ifdef CHECKSUM_EN
    exp_vcyc = 2 * (NW + 1);
`else
    exp_vcyc = 2 * NW;
`endif

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_valid", word_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_word", word_out, 16'h0);
    check_eq("rst_addr", word_addr, 6'd0);
    check_eq("rst_last", word_last, 1'b0);
    check_eq("rst_csum", word_csum, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_ovr", load_overrun, 1'b0);
    rst = 1'b0;

    // 1) ramp frame, full-rate consumer
    for (int k = 0; k < NW; k++) frame_in[k*WW +: WW] = 16'(k << 2);
    @(posedge clk);
    #2;
    n_done_obs = 0;
    pulse_load();
    check_eq("t1_first_valid", word_valid, 1'b1);
    check_eq("t1_first_addr", word_addr, 6'd0);
    check_eq("t1_first_word", word_out, 16'h0);
    wait_idle("t1_timeout");
    @(posedge clk);
    #2;
    check_eq("t1_done_count", n_done_obs, 1);

    // 2) alternating ready: every word held for one stalled cycle
    rdy_mode = 1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (word_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("t2_align", 32'd0, 32'd1);
    n_vobs = 0;
    pulse_load();
    wait_idle("t2_timeout");
    check_eq("t2_valid_cycles", n_vobs, exp_vcyc);

    // 4) load coincident with the final transfer
    rdy_mode = 0;
    rand_frame();
    pulse_load();
    wait_final("t4_timeout");
    for (int k = 0; k < NW; k++) frame_in[k*WW +: WW] = 16'h8000 | 16'(k);
    pulse_load();
    check_eq("t4_addr", word_addr, 6'd0);
    check_eq("t4_word", word_out, 16'h8000);
    check_eq("t4_done", frame_done, 1'b1);
    check_eq("t4_valid", word_valid, 1'b1);
    check_eq("t4_no_ovr", load_overrun, 1'b0);
    wait_idle("t4_drain");

    // 3) load while busy is dropped and recorded
    rdy_mode = 2;
    rand_frame();
    pulse_load();
    wait_addr("t3_timeout", 10);
    rand_frame();
    pulse_load();
    check_eq("t3_ovr", load_overrun, 1'b1);
    wait_idle("t3_drain");
    check_eq("t3_ovr_sticky", load_overrun, 1'b1);

    // 5) asynchronous reset mid-frame
    rand_frame();
    pulse_load();
    wait_addr("t5_timeout", 30);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_valid", word_valid, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_done", frame_done, 1'b0);
    check_eq("t5_ovr", load_overrun, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    check_eq("t5_no_done", frame_done, 1'b0);
    rand_frame();
    pulse_load();
    check_eq("t5_reload", word_valid, 1'b1);
    wait_idle("t5_drain");

`ifdef CHECKSUM_EN
    // 6) checksum beat carries the XOR of the frame
    frame_in = '0;
    frame_in[5*WW +: WW] = 16'h1234;
    n_csum_obs = 0;
    pulse_load();
    wait_idle("t6_timeout");
    check_eq("t6_csum_beats", n_csum_obs, 1);
`endif

    // Random traffic with random loads, some landing on final transfers
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk);
      #2;
      if ($urandom % 8 == 0) rand_frame();
      frame_load = (q.size() == 0) ? (($urandom % 4) == 0) :
                   (q.size() == 1) ? (($urandom % 2) == 0) :
                                     (($urandom % 60) == 0);
    end
    frame_load = 1'b0;
    wait_idle("rand_drain");
    @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
